// File: rtl/store_buffer_be_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_be_if
// Purpose  : Store-push, load-lookup, memory-drain and status bundle for
//            store_buffer_be.
// Revision : 1.0
// ============================================================================
interface store_buffer_be_if #(
  parameter int DATA_BITS  = 32,
  parameter int DATA_BYTES = DATA_BITS / 8,
  parameter int ADDR_BITS  = 32,
  parameter int IDX_BITS   = 3
);
  logic                  flush;
  logic                  push_valid;
  logic [ADDR_BITS-1:0]  push_addr;
  logic [DATA_BITS-1:0]  push_data;
  logic [DATA_BYTES-1:0] push_be;
  logic                  push_ready;
  logic                  ld_valid;
  logic [ADDR_BITS-1:0]  ld_addr;
  logic [DATA_BYTES-1:0] ld_be;
  logic [DATA_BITS-1:0]  ld_data;
  logic                  ld_hit;
  logic                  ld_partial;
  logic                  mem_req;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_BITS-1:0]  mem_data;
  logic [DATA_BYTES-1:0] mem_be;
  logic                  mem_ack;
  logic [IDX_BITS:0]     count;
  logic                  empty;
  logic                  full;

  modport master (
    output flush, push_valid, push_addr, push_data, push_be,
    output ld_valid, ld_addr, ld_be, mem_ack,
    input  push_ready, ld_data, ld_hit, ld_partial,
    input  mem_req, mem_addr, mem_data, mem_be, count, empty, full
  );

  modport slave (
    input  flush, push_valid, push_addr, push_data, push_be,
    input  ld_valid, ld_addr, ld_be, mem_ack,
    output push_ready, ld_data, ld_hit, ld_partial,
    output mem_req, mem_addr, mem_data, mem_be, count, empty, full
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer_be.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_be
// Purpose  : Circular store buffer with byte enables, youngest-entry
//            coalescing, in-order drain and byte-granular load forwarding.
// Revision : 1.0
// ============================================================================
module store_buffer_be #(
  parameter int DATA_BITS     = 32,
  parameter int DATA_BYTES    = DATA_BITS / 8,
  parameter int BYTE_IDX_BITS = 2,
  parameter int ADDR_BITS     = 32,
  parameter int DEPTH         = 8,
  parameter int IDX_BITS      = 3,
  parameter int COALESCE      = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  store_buffer_be_if.slave bus
);
  localparam int WORD_BITS = ADDR_BITS - BYTE_IDX_BITS;
  localparam logic [IDX_BITS:0]   c_depth = (IDX_BITS+1)'(DEPTH);
  localparam logic [IDX_BITS:0]   c_two   = (IDX_BITS+1)'(2);
  localparam logic [IDX_BITS-1:0] c_one   = IDX_BITS'(1);

  logic [DEPTH-1:0]      r_valid;
  logic [WORD_BITS-1:0]  r_word [DEPTH];
  logic [DATA_BITS-1:0]  r_data [DEPTH];
  logic [DATA_BYTES-1:0] r_be   [DEPTH];
  logic [IDX_BITS-1:0]   r_head;
  logic [IDX_BITS-1:0]   r_tail;
  logic [IDX_BITS:0]     r_count;

  logic [WORD_BITS-1:0]  w_push_word;
  logic [WORD_BITS-1:0]  w_ld_word;
  logic [IDX_BITS-1:0]   w_young;
  logic                  w_full;
  logic                  w_match;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_alloc;
  logic                  w_pop;
  logic [IDX_BITS-1:0]   w_slot;
  logic [DATA_BYTES-1:0] w_cov;
  logic [DATA_BITS-1:0]  w_fwd;
  logic [DATA_BITS-1:0]  w_ld_mask;
  logic                  w_hit;

  assign w_push_word = bus.push_addr[ADDR_BITS-1:BYTE_IDX_BITS];
  assign w_ld_word   = bus.ld_addr[ADDR_BITS-1:BYTE_IDX_BITS];
  assign w_young     = r_tail - c_one;
  assign w_full      = (r_count == c_depth);

  // count>=2 keeps a merge out of the head entry that memory may be reading.
  assign w_match = (COALESCE != 0) && (r_count >= c_two) &&
                   (r_word[w_young] == w_push_word);
  assign w_ready = w_match || !w_full;
  assign w_push  = bus.push_valid && w_ready && (bus.push_be != '0);
  assign w_alloc = w_push && !w_match;
  assign w_pop   = bus.mem_ack && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_one;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_one;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && w_push) begin
      if (w_alloc) begin
        r_word[r_tail] <= w_push_word;
        r_data[r_tail] <= bus.push_data;
        r_be[r_tail]   <= bus.push_be;
      end else begin
        for (int b = 0; b < DATA_BYTES; b++) begin
          if (bus.push_be[b]) begin
            r_data[w_young][b*8 +: 8] <= bus.push_data[b*8 +: 8];
          end
        end
        r_be[w_young] <= r_be[w_young] | bus.push_be;
      end
    end
  end

  // Oldest-to-youngest walk so later matches overwrite earlier ones.
  always_comb begin
    w_cov  = '0;
    w_fwd  = '0;
    w_slot = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = r_head + IDX_BITS'(k);
      if (r_valid[w_slot] && (r_word[w_slot] == w_ld_word)) begin
        for (int b = 0; b < DATA_BYTES; b++) begin
          if (r_be[w_slot][b]) begin
            w_cov[b]          = 1'b1;
            w_fwd[b*8 +: 8]   = r_data[w_slot][b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane_mask
    assign w_ld_mask[g*8 +: 8] = {8{bus.ld_be[g]}};
  end

  assign w_hit = bus.ld_valid && (bus.ld_be != '0) &&
                 ((w_cov & bus.ld_be) == bus.ld_be);

  assign bus.ld_hit     = w_hit;
  assign bus.ld_partial = bus.ld_valid && ((w_cov & bus.ld_be) != '0) && !w_hit;
  assign bus.ld_data    = bus.ld_valid ? (w_fwd & w_ld_mask) : '0;

  assign bus.push_ready = w_ready;
  assign bus.mem_req    = r_valid[r_head];
  assign bus.mem_addr   = r_valid[r_head] ?
                          {r_word[r_head], {BYTE_IDX_BITS{1'b0}}} : '0;
  assign bus.mem_data   = r_valid[r_head] ? r_data[r_head] : '0;
  assign bus.mem_be     = r_valid[r_head] ? r_be[r_head] : '0;
  assign bus.count      = r_count;
  assign bus.empty      = (r_count == '0);
  assign bus.full       = w_full;
endmodule
`default_nettype wire

// File: tb/tb_store_buffer_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer_be
// Purpose  : Queue-model checker plus directed vectors for store_buffer_be.
// Revision : 1.0
// ============================================================================
module tb_store_buffer_be;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_addr = '0;
  logic [31:0] push_data = '0;
  logic [3:0]  push_be = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_be = '0;
  logic        mem_ack = 1'b0;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  store_buffer_be_if #(.DATA_BITS(32), .ADDR_BITS(32), .IDX_BITS(3)) bus ();
  store_buffer_be_if #(.DATA_BITS(32), .ADDR_BITS(32), .IDX_BITS(3)) bus_nc ();

  store_buffer_be #(.DATA_BITS(32), .BYTE_IDX_BITS(2), .ADDR_BITS(32),
                    .DEPTH(DEPTH), .IDX_BITS(3), .COALESCE(1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  store_buffer_be #(.DATA_BITS(32), .BYTE_IDX_BITS(2), .ADDR_BITS(32),
                    .DEPTH(DEPTH), .IDX_BITS(3), .COALESCE(0))
    dut_nc (.clk(clk), .rst(rst), .bus(bus_nc));

  assign bus.flush = flush;          assign bus_nc.flush = flush;
  assign bus.push_valid = push_valid; assign bus_nc.push_valid = push_valid;
  assign bus.push_addr = push_addr;  assign bus_nc.push_addr = push_addr;
  assign bus.push_data = push_data;  assign bus_nc.push_data = push_data;
  assign bus.push_be = push_be;      assign bus_nc.push_be = push_be;
  assign bus.ld_valid = ld_valid;    assign bus_nc.ld_valid = ld_valid;
  assign bus.ld_addr = ld_addr;      assign bus_nc.ld_addr = ld_addr;
  assign bus.ld_be = ld_be;          assign bus_nc.ld_be = ld_be;
  assign bus.mem_ack = mem_ack;      assign bus_nc.mem_ack = mem_ack;

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  b;
  } ent_t;

  ent_t q[$];
  ent_t m_e;
  int   m_n;
  bit   m_match;
  bit   m_pop;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a plain queue, oldest at index 0.
  always @(posedge clk) begin
    m_n = q.size();
    if (rst) begin
      q.delete();
      started = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      m_match = (m_n >= 2) && (q[m_n-1].w == push_addr[31:2]);
      m_pop   = (m_n > 0) && mem_ack;
      if (push_valid && (m_match || m_n < DEPTH) && push_be != 4'h0) begin
        if (m_match) begin
          m_e = q[m_n-1];
          for (int b = 0; b < 4; b++)
            if (push_be[b]) m_e.d[b*8 +: 8] = push_data[b*8 +: 8];
          m_e.b = m_e.b | push_be;
          q[m_n-1] = m_e;
        end else begin
          m_e.w = push_addr[31:2];
          m_e.d = push_data;
          m_e.b = push_be;
          q.push_back(m_e);
        end
      end
      if (m_pop) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    int          n;
    logic [3:0]  cov;
    logic [31:0] fwd;
    bit          found;
    bit          hit;
    if (started) begin
      n = q.size();
      check("mem_req", bus.mem_req, n > 0);
      check("mem_addr", bus.mem_addr, n > 0 ? {q[0].w, 2'b00} : 32'h0);
      check("mem_data", bus.mem_data, n > 0 ? q[0].d : 32'h0);
      check("mem_be", bus.mem_be, n > 0 ? q[0].b : 4'h0);
      check("count", bus.count, n);
      check("empty", bus.empty, n == 0);
      check("full", bus.full, n == DEPTH);
      check("push_ready", bus.push_ready,
            (n < DEPTH) || (n >= 2 && q[n-1].w == push_addr[31:2]));
      cov = '0;
      fwd = '0;
      for (int b = 0; b < 4; b++) begin
        found = 1'b0;
        for (int k = n - 1; k >= 0; k--) begin
          if (!found && q[k].w == ld_addr[31:2] && q[k].b[b]) begin
            found = 1'b1;
            cov[b] = 1'b1;
            if (ld_be[b]) fwd[b*8 +: 8] = q[k].d[b*8 +: 8];
          end
        end
      end
      hit = ld_valid && ld_be != 4'h0 && ((cov & ld_be) == ld_be);
      check("ld_hit", bus.ld_hit, hit);
      check("ld_partial", bus.ld_partial, ld_valid && ((cov & ld_be) != 4'h0) && !hit);
      check("ld_data", bus.ld_data, ld_valid ? fwd : 32'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
    push_be    = be;
    tick();
    push_valid = 1'b0;
    push_be    = 4'h0;
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] be);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_be    = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    look();
    check("rst_count", bus.count, 0);
    check("rst_ready", bus.push_ready, 1);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_hit", bus.ld_hit, 0);
    rst = 1'b0;
    tick();

    // Single store and drain
    push(32'h100, 32'hAABBCCDD, 4'hF);
    look();
    check("t1_req", bus.mem_req, 1);
    check("t1_addr", bus.mem_addr, 32'h100);
    check("t1_data", bus.mem_data, 32'hAABBCCDD);
    check("t1_count", bus.count, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    look();
    check("t1_req_off", bus.mem_req, 0);
    check("t1_empty", bus.empty, 1);
    push(32'h600, 32'h12345678, 4'h0);
    look();
    check("be0_count", bus.count, 0);

    // Coalescing
    push(32'h200, 32'h00001122, 4'b0011);
    push(32'h300, 32'h00005566, 4'b0011);
    push(32'h302, 32'h33440000, 4'b1100);
    look();
    check("co_count", bus.count, 2);
    check("nc_count", bus_nc.count, 3);
    load(32'h300, 4'hF);
    look();
    check("co_hit", bus.ld_hit, 1);
    check("co_data", bus.ld_data, 32'h33445566);
    ld_valid = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    look();
    check("co_addr2", bus.mem_addr, 32'h300);
    check("co_be2", bus.mem_be, 4'hF);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Forwarding, youngest wins
    push(32'h400, 32'h000000EE, 4'b0001);
    push(32'h400, 32'h000000FF, 4'b0001);
    load(32'h400, 4'b0001);
    look();
    check("fw_count", bus.count, 2);
    check("fw_hit", bus.ld_hit, 1);
    check("fw_data", bus.ld_data, 32'h000000FF);
    load(32'h400, 4'b0011);
    look();
    check("fw_p_hit", bus.ld_hit, 0);
    check("fw_partial", bus.ld_partial, 1);
    load(32'h404, 4'b0001);
    look();
    check("fw_miss_h", bus.ld_hit, 0);
    check("fw_miss_p", bus.ld_partial, 0);
    ld_valid = 1'b0;

    // Flush with head being acked
    push(32'h500, 32'h55555555, 4'hF);
    flush = 1'b1;
    mem_ack = 1'b1;
    tick();
    flush = 1'b0;
    mem_ack = 1'b0;
    load(32'h400, 4'b0001);
    look();
    check("fl_count", bus.count, 0);
    check("fl_req", bus.mem_req, 0);
    check("fl_hit", bus.ld_hit, 0);
    check("fl_partial", bus.ld_partial, 0);
    ld_valid = 1'b0;

    // Fill, refused push with pop, wrap
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + i * 4, 32'h1000 + i, 4'hF);
    push_valid = 1'b1;
    push_addr  = 32'h2000;
    push_data  = 32'h00002000;
    push_be    = 4'hF;
    mem_ack    = 1'b1;
    look();
    check("fu_full", bus.full, 1);
    check("fu_ready", bus.push_ready, 0);
    tick();
    push_valid = 1'b0;
    mem_ack    = 1'b0;
    look();
    check("fu_count7", bus.count, 7);
    check("fu_head", bus.mem_addr, 32'h1004);
    push(32'h2000, 32'h00002000, 4'hF);
    push_valid = 1'b1;
    push_data  = 32'hCAFE0000;
    push_be    = 4'b1100;
    look();
    check("fu_full8", bus.full, 1);
    check("fu_merge_rdy", bus.push_ready, 1);
    tick();
    push_valid = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      look();
      check("dr_addr", bus.mem_addr, 64'(32'h1000 + i * 4));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    look();
    check("dr_wrap_addr", bus.mem_addr, 32'h2000);
    check("dr_wrap_data", bus.mem_data, 32'hCAFE2000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;

    // Reset between acks
    push(32'h700, 32'h70, 4'hF);
    push(32'h704, 32'h74, 4'hF);
    push(32'h708, 32'h78, 4'hF);
    mem_ack = 1'b1;
    tick();
    look();
    check("rs_mid_addr", bus.mem_addr, 32'h704);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ack = 1'b0;
    look();
    check("rs_count", bus.count, 0);
    check("rs_req", bus.mem_req, 0);
    check("rs_addr", bus.mem_addr, 0);
    check("rs_data", bus.mem_data, 0);
    check("rs_be", bus.mem_be, 0);
    check("rs_ready", bus.push_ready, 1);
    check("rs_empty", bus.empty, 1);
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    look();
    check("rs_stay_idle", bus.mem_req, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/store_buffer_be.md
# store_buffer_be

Parametrised store buffer with per-byte enables, sitting between the processor's memory stage and the data cache write port. It queues committed stores (sub-word included) in a circular FIFO and drains them in order to memory with a req/ack handshake. It coalesces a new store into the youngest entry when the word address matches. Loads get byte-granular youngest-wins forwarding, reported as full hit, partial overlap or miss.

## Interface
- DATA_BITS, 32, store/load data width; must be a multiple of 8
- DATA_BYTES, DATA_BITS/8, byte lanes
- BYTE_IDX_BITS, 2, log2(DATA_BYTES)
- ADDR_BITS, 32, address width
- DEPTH, 8, number of entries; power of 2, at least 2
- IDX_BITS, 3, log2(DEPTH)
- COALESCE, 1, 1 enables merging into the youngest entry; 0 disables it

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of every entry, including an un-acked head
- push_valid  in  1  store request
- push_addr  in  ADDR_BITS  store byte address; low BYTE_IDX_BITS bits ignored
- push_data  in  DATA_BITS  store data, lane-aligned
- push_be  in  DATA_BYTES  byte enables
- push_ready  out  1  store accepted this cycle when push_valid is also high
- ld_valid  in  1  load lookup
- ld_addr  in  ADDR_BITS  load byte address; low bits ignored
- ld_be  in  DATA_BYTES  bytes requested
- ld_data  out  DATA_BITS  forwarded bytes; uncovered lanes read 0
- ld_hit  out  1  every requested byte is covered by the buffer
- ld_partial  out  1  some, but not all, requested bytes are covered; the load must stall
- mem_req  out  1  head entry is valid
- mem_addr  out  ADDR_BITS  head word address; low bits 0
- mem_data  out  DATA_BITS  head data
- mem_be  out  DATA_BYTES  head byte enables
- mem_ack  in  1  memory accepts head this cycle
- count  out  IDX_BITS+1  valid entries, 0..DEPTH
- empty, full  out  1  count==0 and count==DEPTH

## Operation
- State: per-entry valid, word address, data, be; head ptr, tail ptr (IDX_BITS, wrap modulo DEPTH); count register.
- Coalesce match requires all of the following:
  - COALESCE=1
  - count>=1
  - the youngest entry (tail-1) has the same word address as push_addr
  - the youngest entry is not the head while mem_req is high, so a merge never lands in the entry being drained; effectively this means count>=2
- push_ready = coalesce match OR !full. Full refuses a non-matching push even when mem_ack pops in the same cycle.
- Accepted push with a match: youngest entry lanes with push_be set take push_data, and be |= push_be. count and tail are unchanged.
- Accepted push without a match: write the entry at tail, tail+1, count+1.
- push_be==0: accepted, with no state change.
- Drain: mem_* driven from head, held stable until mem_ack. On mem_req && mem_ack: clear head valid, head+1, count-1. mem_ack while empty is ignored.
- Simultaneous allocating push and pop: count is unchanged, both pointers advance.
- Forwarding (combinational), per requested lane:
  - select the youngest valid entry, walking from tail-1 back to head, whose word address matches and whose be bit is set
  - a lane with no such entry is uncovered
  - ld_hit = ld_valid && all ld_be lanes covered && ld_be!=0
  - ld_partial = ld_valid && at least one lane covered && !ld_hit
  - with ld_valid low: ld_hit=0, ld_partial=0, ld_data=0
- Priority: rst > flush > push/pop.
- rst or flush sets all valid bits to 0, head=tail=0, count=0.

## Timing
- Reset values:
  - push_ready=1, empty=1, full=0, count=0
  - mem_req=0, mem_addr/mem_data/mem_be=0
  - ld_hit=0, ld_partial=0, ld_data=0
- A push accepted in cycle n is visible to forwarding, mem_*, and count from cycle n+1. Forwarding in cycle n sees pre-push state only.
- First push into an empty buffer: mem_req high in cycle n+1.
- mem_ack in cycle n: the next entry (or mem_req=0) is presented in cycle n+1.
- flush asserted in cycle n: mem_req=0 in n+1, even if mem_ack was high in n.
- Wrap-around: pointers roll DEPTH-1 -> 0 with no bubble. DEPTH consecutive pushes with no ack give full=1 and push_ready=0 for non-matching addresses.

## Test plan
- Reset, then push 0x100 with data 0xAABBCCDD and be 1111 -> next cycle mem_req=1, mem_addr=0x100, count=1. Ack -> mem_req=0, empty=1.
- Coalesce: push 0x200 be 0011 data 0x00001122, then 0x300, then 0x300 be 1100 data 0x33440000 -> count=2, and the second entry at 0x300 has be=1100 merged. With COALESCE=0 -> count=3.
- Forwarding: entries 0x400 be 0001 data 0x..EE, then 0x400 be 0001 data 0x..FF. Load 0x400 with ld_be 0001 -> ld_hit=1, ld_data=0x000000FF. Load with ld_be 0011 -> ld_partial=1, ld_hit=0.
- Full/wrap: 8 pushes to distinct addresses without ack -> full=1 and push_ready=0. A 9th push plus mem_ack in the same cycle -> push refused, count=7. Push again -> accepted, tail wraps to slot 0, drain order preserved.
- flush with 3 entries and mem_req/mem_ack both high -> next cycle count=0, mem_req=0, load lookup misses.
- rst asserted mid-drain between two acks -> all outputs at reset values next cycle. The remaining entries are never presented.
